// File: rtl/color_subcarrier_gen.sv
// rtl/color_subcarrier_gen.sv - phase-accumulator 4x colour-subcarrier generator with glitch-free standard switching
// Optional: define COLORCLK_DITHER_EN to dither the phase increment with a 16-bit LFSR.
module color_subcarrier_gen #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int          ACC_W      = 32,
    parameter int unsigned F_PAL4X    = 17734475,
    parameter int unsigned F_NTSC4X   = 14318182,
    parameter int unsigned F_PALN4X   = 14328225,
    parameter int          LOCK_WRAPS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       mode,
    input  logic       altern,
    output logic       clkcolor4x,
    output logic       clkcolor4x_en,
    output logic       locked,
    output logic [1:0] active_std
);

    // Rounded (F * 2^ACC_W + CLK_HZ/2) / CLK_HZ, done as long division so nothing overflows 64 bits.
    function automatic logic [63:0] calc_inc(input logic [63:0] f_hz);
        logic [63:0] q;
        logic [63:0] r;
        logic [63:0] c;
        c = 64'(CLK_HZ);
        q = f_hz / c;
        r = f_hz % c;
        for (int i = 0; i < ACC_W; i++) begin
            q = q << 1;
            r = r << 1;
            if (r >= c) begin
                r = r - c;
                q = q + 64'd1;
            end
        end
        if (r + (c >> 1) >= c) begin
            q = q + 64'd1;
        end
        return q;
    endfunction

    localparam logic [ACC_W-1:0] INC_PAL  = ACC_W'(calc_inc(64'(F_PAL4X)));
    localparam logic [ACC_W-1:0] INC_NTSC = ACC_W'(calc_inc(64'(F_NTSC4X)));
    localparam logic [ACC_W-1:0] INC_PALN = ACC_W'(calc_inc(64'(F_PALN4X)));
    localparam logic [7:0]       LOCK_CNT = 8'(LOCK_WRAPS);

    localparam logic [1:0] STD_PAL     = 2'b00;
    localparam logic [1:0] STD_NTSC    = 2'b01;
    localparam logic [1:0] STD_PALN    = 2'b10;
    localparam logic [1:0] STD_NTSC443 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LOCKED,
        ST_PENDING
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       active_std_q, active_std_d;
    logic [7:0]       wrap_cnt_q, wrap_cnt_d;
    logic             clkcolor4x_q, clkcolor4x_d;
    logic             clkcolor4x_en_q, clkcolor4x_en_d;
    logic             locked_q, locked_d;
    logic             mode_meta_q, mode_meta_d, mode_sync_q, mode_sync_d;
    logic             altern_meta_q, altern_meta_d, altern_sync_q, altern_sync_d;

    logic [1:0]       req_std;
    logic [ACC_W-1:0] inc_sel;
    logic [ACC_W-1:0] inc_eff;
    logic [ACC_W:0]   acc_sum;
    logic             carry;
    logic             running;

    assign running = enable && (state_q != ST_IDLE);

    always_comb begin
        mode_meta_d   = mode;
        mode_sync_d   = mode_meta_q;
        altern_meta_d = altern;
        altern_sync_d = altern_meta_q;
        case ({mode_sync_q, altern_sync_q})
            2'b00:   req_std = STD_PAL;
            2'b01:   req_std = STD_PALN;
            2'b10:   req_std = STD_NTSC;
            default: req_std = STD_NTSC443;
        endcase
        // NTSC-4.43 reuses the PAL subcarrier frequency.
        case (active_std_q)
            STD_NTSC: inc_sel = INC_NTSC;
            STD_PALN: inc_sel = INC_PALN;
            default:  inc_sel = INC_PAL;
        endcase
    end

`ifdef COLORCLK_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (running) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign inc_eff = inc_sel + ACC_W'(lfsr_q[0]);
`else
    assign inc_eff = inc_sel;
`endif

    assign acc_sum = {1'b0, acc_q} + {1'b0, inc_eff};
    assign carry   = acc_sum[ACC_W];

    // Standard changes are only ever applied on a carry, so no output phase is cut short.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        active_std_d = active_std_q;
        wrap_cnt_d   = wrap_cnt_q;
        if (!enable) begin
            state_d = ST_IDLE;
            acc_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    acc_d        = '0;
                    active_std_d = req_std;
                    wrap_cnt_d   = '0;
                    state_d      = ST_SETTLE;
                end
                ST_SETTLE: begin
                    acc_d = acc_sum[ACC_W-1:0];
                    if (carry) begin
                        if (req_std != active_std_q) begin
                            active_std_d = req_std;
                            wrap_cnt_d   = '0;
                        end else begin
                            wrap_cnt_d = wrap_cnt_q + 8'd1;
                            if (wrap_cnt_q + 8'd1 == LOCK_CNT) begin
                                state_d = ST_LOCKED;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    acc_d = acc_sum[ACC_W-1:0];
                    if (req_std != active_std_q) begin
                        state_d = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    acc_d = acc_sum[ACC_W-1:0];
                    if (req_std == active_std_q) begin
                        state_d = ST_LOCKED;
                    end else if (carry) begin
                        active_std_d = req_std;
                        wrap_cnt_d   = '0;
                        state_d      = ST_SETTLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end
            endcase
        end
        locked_d        = (state_d == ST_LOCKED) || (state_d == ST_PENDING);
        clkcolor4x_d    = running ? acc_q[ACC_W-1] : 1'b1;
        clkcolor4x_en_d = running && !clkcolor4x_q && acc_q[ACC_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            acc_q           <= '0;
            active_std_q    <= STD_PAL;
            wrap_cnt_q      <= '0;
            clkcolor4x_q    <= 1'b1;
            clkcolor4x_en_q <= 1'b0;
            locked_q        <= 1'b0;
            mode_meta_q     <= 1'b0;
            mode_sync_q     <= 1'b0;
            altern_meta_q   <= 1'b0;
            altern_sync_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            active_std_q    <= active_std_d;
            wrap_cnt_q      <= wrap_cnt_d;
            clkcolor4x_q    <= clkcolor4x_d;
            clkcolor4x_en_q <= clkcolor4x_en_d;
            locked_q        <= locked_d;
            mode_meta_q     <= mode_meta_d;
            mode_sync_q     <= mode_sync_d;
            altern_meta_q   <= altern_meta_d;
            altern_sync_q   <= altern_sync_d;
        end
    end

    assign clkcolor4x    = clkcolor4x_q;
    assign clkcolor4x_en = clkcolor4x_en_q;
    assign locked        = locked_q;
    assign active_std    = active_std_q;

endmodule
